// File: rtl/hamming_dec.sv
// rtl/hamming_dec.sv - two-stage (12,8) Hamming SEC decoder; error counters under HAMMING_DEC_COUNTERS_EN
module hamming_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       data_out,
    output logic [3:0]       syndrome,
    output logic             corrected,
    output logic             uncorrectable,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [3:0] SYN_LAST_POS = 4'd12;

    function automatic logic [3:0] calc_syndrome(input logic [11:0] c);
        logic s1, s2, s4, s8;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
        s8 = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
        return {s8, s4, s2, s1};
    endfunction

    function automatic logic [7:0] extract_payload(input logic [11:0] c);
        return {c[11:8], c[6:4], c[2]};
    endfunction

    logic        s1_valid_q, s1_valid_d;
    logic [11:0] s1_code_q, s1_code_d;
    logic [3:0]  s1_syn_q, s1_syn_d;

    logic        s2_valid_q, s2_valid_d;
    logic [7:0]  s2_data_q, s2_data_d;
    logic [3:0]  s2_syn_q, s2_syn_d;
    logic        s2_corr_q, s2_corr_d;
    logic        s2_unc_q, s2_unc_d;

    logic        s2_adv;
    logic        s1_load;
    logic        s2_load;
    logic [11:0] fixed_code;
    logic        syn_corr;
    logic        syn_unc;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_adv;

    assign syn_corr = (s1_syn_q != 4'd0) && (s1_syn_q <= SYN_LAST_POS);
    assign syn_unc  = (s1_syn_q > SYN_LAST_POS);

    // Syndrome 13..15 matches no loop index, so those words pass through raw.
    always_comb begin
        fixed_code = s1_code_q;
        for (int i = 0; i < 12; i++) begin
            if (s1_syn_q == 4'(i + 1)) begin
                fixed_code[i] = ~s1_code_q[i];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_code_d  = code_in;
            s1_syn_d   = calc_syndrome(code_in);
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_corr_d  = s2_corr_q;
        s2_unc_d   = s2_unc_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_data_d = extract_payload(fixed_code);
            s2_syn_d  = s1_syn_q;
            s2_corr_d = syn_corr;
            s2_unc_d  = syn_unc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_corr_q  <= 1'b0;
            s2_unc_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_syn_q   <= s2_syn_d;
            s2_corr_q  <= s2_corr_d;
            s2_unc_q   <= s2_unc_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign data_out      = s2_data_q;
    assign syndrome      = s2_syn_q;
    assign corrected     = s2_corr_q;
    assign uncorrectable = s2_unc_q;

`ifdef HAMMING_DEC_COUNTERS_EN
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic             out_fire;

    assign out_fire = s2_valid_q && out_ready;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clear) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_fire) begin
            if (s2_corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (s2_unc_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`else
    logic unused_cnt_clear;

    assign unused_cnt_clear = cnt_clear;
    assign corr_cnt         = '0;
    assign uncorr_cnt       = '0;
`endif

endmodule

// File: tb/tb_hamming_dec.sv
// tb/tb_hamming_dec.sv - randomized scoreboard bench for hamming_dec
module tb_hamming_dec;

    localparam int CNT_W = 2;
`ifdef HAMMING_DEC_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      code_in;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       data_out;
    logic [3:0]       syndrome;
    logic             corrected;
    logic             uncorrectable;
    logic             cnt_clear;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int errors = 0;
    int checks = 0;

    // Expected results, oldest first: {uncorrectable, corrected, syndrome, data}
    logic [13:0]      sb[$];
    logic [CNT_W-1:0] m_corr;
    logic [CNT_W-1:0] m_unc;

    hamming_dec #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .code_in       (code_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .syndrome      (syndrome),
        .corrected     (corrected),
        .uncorrectable (uncorrectable),
        .cnt_clear     (cnt_clear),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Syndrome is the XOR of the 1-based positions of all set bits.
    function automatic logic [13:0] ref_decode(input logic [11:0] c);
        logic [3:0]  s;
        logic [11:0] w;
        logic [7:0]  d;
        int          k;
        s = 4'd0;
        for (int i = 0; i < 12; i++) if (c[i]) s ^= 4'(i + 1);
        w = c;
        if (s >= 4'd1 && s <= 4'd12) w[s - 4'd1] = ~w[s - 4'd1];
        d = 8'd0;
        k = 0;
        for (int p = 1; p <= 12; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = w[p - 1];
                k++;
            end
        end
        return {(s >= 4'd13), (s >= 4'd1 && s <= 4'd12), s, d};
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] d);
        logic [11:0] w;
        logic [3:0]  s;
        int          k;
        w = 12'd0;
        k = 0;
        for (int p = 1; p <= 12; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p - 1] = d[k];
                k++;
            end
        end
        s = 4'd0;
        for (int i = 0; i < 12; i++) if (w[i]) s ^= 4'(i + 1);
        for (int b = 0; b < 4; b++) if (s[b]) w[(1 << b) - 1] = 1'b1;
        return w;
    endfunction

    function automatic logic [11:0] rand_word();
        logic [11:0] w;
        int          n;
        if ($urandom_range(0, 1) == 0) return 12'($urandom);
        w = encode(8'($urandom));
        n = $urandom_range(0, 2);
        for (int e = 0; e < n; e++) w[$urandom_range(0, 11)] ^= 1'b1;
        return w;
    endfunction

    // One clock: drive at negedge, sample 1ns later, score what the next posedge commits.
    task automatic cycle(input logic v, input logic [11:0] c, input logic ordy, input logic clr);
        logic [13:0] f;
        @(negedge clk);
        in_valid  = v;
        code_in   = c;
        out_ready = ordy;
        cnt_clear = clr;
        #1;
        check("in_ready", 32'(in_ready), 32'((sb.size() < 2) || ordy));
        check("corr_cnt", 32'(corr_cnt), CNT_EN ? 32'(m_corr) : 32'd0);
        check("uncorr_cnt", 32'(uncorr_cnt), CNT_EN ? 32'(m_unc) : 32'd0);
        f = 14'd0;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                f = sb[0];
                check("data_out", 32'(data_out), 32'(f[7:0]));
                check("syndrome", 32'(syndrome), 32'(f[11:8]));
                check("corrected", 32'(corrected), 32'(f[12]));
                check("uncorrectable", 32'(uncorrectable), 32'(f[13]));
            end
        end
        if (clr) begin
            m_corr = '0;
            m_unc  = '0;
        end else if (out_valid && ordy && sb.size() != 0) begin
            if (f[12] && m_corr != '1) m_corr++;
            if (f[13] && m_unc != '1) m_unc++;
        end
        if (out_valid && ordy && sb.size() != 0) void'(sb.pop_front());
        if (v && in_ready) sb.push_back(ref_decode(c));
    endtask

    task automatic send_check(input string tag, input logic [11:0] c, input logic [7:0] ed,
                              input logic [3:0] es, input logic ec, input logic eu);
        cycle(1'b1, c, 1'b1, 1'b0);
        cycle(1'b0, 12'd0, 1'b1, 1'b0);
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        cycle(1'b0, 12'd0, 1'b1, 1'b0);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(ed));
        check({tag, "_syn"}, 32'(syndrome), 32'(es));
        check({tag, "_corr"}, 32'(corrected), 32'(ec));
        check({tag, "_unc"}, 32'(uncorrectable), 32'(eu));
        cycle(1'b0, 12'd0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_syndrome"}, 32'(syndrome), 32'd0);
        check({tag, "_corrected"}, 32'(corrected), 32'd0);
        check({tag, "_uncorrectable"}, 32'(uncorrectable), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'd0);
        check({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] bw[4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        code_in   = 12'd0;
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        m_corr    = '0;
        m_unc     = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("rst_release");

        send_check("clean", 12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
        check("clean_corr_cnt", 32'(corr_cnt), 32'd0);
        send_check("data_err", 12'hA37, 8'hA5, 4'd5, 1'b1, 1'b0);
        check("data_err_corr_cnt", 32'(corr_cnt), CNT_EN ? 32'd1 : 32'd0);
        send_check("par_err", 12'hAA7, 8'hA5, 4'd8, 1'b1, 1'b0);
        send_check("uncorr", 12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
        check("uncorr_cnt_1", 32'(uncorr_cnt), CNT_EN ? 32'd1 : 32'd0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 12'hA37, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 12'd0, 1'b1, 1'b0);
        check("sat_corr_cnt", 32'(corr_cnt), CNT_EN ? 32'd3 : 32'd0);
        cycle(1'b1, 12'hA37, 1'b1, 1'b0);
        cycle(1'b0, 12'd0, 1'b1, 1'b0);
        cycle(1'b0, 12'd0, 1'b1, 1'b1);
        check("clr_with_corr_valid", 32'(out_valid && corrected), 32'd1);
        cycle(1'b0, 12'd0, 1'b1, 1'b0);
        check("clr_corr_cnt", 32'(corr_cnt), 32'd0);

        for (int i = 0; i < 4; i++) bw[i] = rand_word();
        cycle(1'b1, bw[0], 1'b0, 1'b0);
        check("bp_ready0", 32'(in_ready), 32'd1);
        cycle(1'b1, bw[1], 1'b0, 1'b0);
        check("bp_ready1", 32'(in_ready), 32'd1);
        cycle(1'b1, bw[2], 1'b0, 1'b0);
        check("bp_ready2", 32'(in_ready), 32'd0);
        cycle(1'b1, bw[2], 1'b0, 1'b0);
        check("bp_ready3", 32'(in_ready), 32'd0);
        cycle(1'b1, bw[2], 1'b1, 1'b0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, bw[3], 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 12'd0, 1'b1, 1'b0);
        check("bp_drained", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0));
        end

        for (int i = 0; i < 3; i++) cycle(1'b1, rand_word(), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_state("mid_rst");
        sb.delete();
        m_corr = '0;
        m_unc  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 12'd0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) cycle(1'b1, rand_word(), 1'b1, 1'b0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) cycle(1'b0, 12'd0, 1'b1, 1'b0);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_dec.md
# hamming_dec

Single-error-correcting decoder for the 12-bit Hamming codeword produced by the team's `hamming` encoder. It recovers the 8-bit payload, corrects any single-bit error, and flags syndromes that cannot point at a codeword bit. It sits on the receive side of the link, behind the deserializer. It is a two-stage valid/ready pipeline with optional error statistics.

## Interface
- `CNT_W`, default 16: width of the error statistic counters.

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: codeword valid.
- `in_ready` output 1: decoder can accept a codeword.
- `code_in` input 12: received codeword; bit i is Hamming position i+1.
- `out_valid` output 1: decoded result valid.
- `out_ready` input 1: downstream accepts the result.
- `data_out` output 8: decoded payload.
- `syndrome` output 4: computed syndrome, {s8,s4,s2,s1}.
- `corrected` output 1: a single-bit error was corrected.
- `uncorrectable` output 1: syndrome is 13..15; the payload is passed through uncorrected.
- `cnt_clear` input 1: synchronous clear of both counters.
- `corr_cnt` output CNT_W: count of corrected words, saturating.
- `uncorr_cnt` output CNT_W: count of uncorrectable words, saturating.

## Operation
- Codeword layout, using 0-based bit indices:
  - Parity bits at indices 0, 1, 3 and 7.
  - Payload bits d7..d4 at indices 11..8.
  - Payload bits d3..d1 at indices 6..4.
  - Payload bit d0 at index 2.
- Syndrome bits:
  - s1 = XOR of indices 0, 2, 4, 6, 8, 10.
  - s2 = XOR of indices 1, 2, 5, 6, 9, 10.
  - s4 = XOR of indices 3, 4, 5, 6, 11.
  - s8 = XOR of indices 7, 8, 9, 10, 11.
- Syndrome outcomes:
  - S = 0: clean word; `corrected` = 0, `uncorrectable` = 0.
  - S in 1..12: flip bit S-1, then extract the payload; `corrected` = 1. A parity-bit hit (S = 1, 2, 4 or 8) still asserts `corrected` and leaves the payload unchanged.
  - S in 13..15: no flip, raw payload extracted; `uncorrectable` = 1.
- Double errors that alias to S ≤ 12 are miscorrected. This is by design, since there is no overall parity bit.
- Pipeline:
  - Stage 1 (S1) registers `code_in` and the syndrome.
  - Stage 2 (S2) registers the corrected payload, the flags and the syndrome.
- Advance rules:
  - `s2_adv = !s2_valid || out_ready`.
  - `in_ready = !s1_valid || s2_adv`.
  - S1 loads when `in_valid && in_ready`.
  - S2 loads from S1 when `s1_valid && s2_adv`.
  - A valid that is not reloaded clears when its stage is drained.
- Output hold: while `out_valid && !out_ready`, all S2 outputs hold stable.
- Counters:
  - Each counter increments once per word accepted at the output (`out_valid && out_ready`) whose flag is set.
  - Counters saturate at all-ones.
  - `cnt_clear` has priority over an increment in the same cycle.

## Timing
- Reset values: `out_valid`=0, `data_out`=0, `syndrome`=0, `corrected`=0, `uncorrectable`=0, counters=0, internal valids=0. `in_ready`=1 out of reset.
- Latency: a word accepted in cycle N is presented with `out_valid`=1 in cycle N+2.
- Throughput: one word per cycle while `out_ready`=1.
- Backpressure: with `out_ready` held at 0, the pipeline holds 2 words and `in_ready` falls to 0 on the cycle after the second accept. Releasing `out_ready` restores `in_ready` combinationally in the same cycle.
- Simultaneous accept and drain keeps full throughput with no bubble.
- Reset asserted mid-stream discards all in-flight words immediately, with no partial output.

## Configuration
- `HAMMING_DEC_COUNTERS_EN`:
  - Defined: `corr_cnt`, `uncorr_cnt` and `cnt_clear` are implemented as specified.
  - Undefined: the counter logic is removed, both counters are tied to 0, and `cnt_clear` is ignored. Ports stay present and the decode path is identical.

## Test plan
- Clean word: `code_in`=0xA27, `out_ready`=1 → two cycles later `data_out`=0xA5, `syndrome`=0, `corrected`=0, `uncorrectable`=0.
- Single data error: `code_in`=0xA37 (index 4 flipped) → `data_out`=0xA5, `syndrome`=5, `corrected`=1; `corr_cnt` increments to 1.
- Parity-bit error: `code_in`=0xAA7 (index 7 flipped) → `data_out`=0xA5, `syndrome`=8, `corrected`=1.
- Uncorrectable: `code_in`=0x226 (indices 11 and 0 flipped) → `syndrome`=13, `uncorrectable`=1, `data_out`=0x25; `uncorr_cnt` increments to 1.
- Backpressure:
  - Stimulus: stream 4 words with `out_ready`=0.
  - Required: `in_ready` drops after 2 accepts and outputs stay stable.
  - Then raise `out_ready`: all 4 words emerge in order, no loss or duplication.
- Saturation and clear:
  - Build with `CNT_W`=2 and send 5 single-error words → `corr_cnt` stops at 3.
  - Assert `cnt_clear` together with a corrected output → `corr_cnt`=0.
  - Macro undefined → counters stay 0.
